hs32_ahb_sram: RTL and testbench
================================

# hs32_ahb_sram

AHB-lite slave that bridges the HS32 data bus to a single-port synchronous SRAM. It is the responder on the bus driven by the HS32 load/store unit. It decodes byte, halfword and word transfers into SRAM byte strobes, inserts programmable wait states, and resolves the write-then-read port conflict on its single SRAM port. Illegal transfers get the two-cycle AHB ERROR response.

## Interface
- ADDR_W, 10, SRAM word-address width; window size is 4<<ADDR_W bytes
- BASE, 32'h0, byte base address of the window; must be aligned to the window size
- WAIT, 0, extra data-phase wait states per transfer (0..15)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- HSEL_i  in  1  slave select
- HADDR_i  in  32  address-phase address
- HWRITE_i  in  1  1 = write
- HSIZE_i  in  3  0 = byte, 1 = half, 2 = word; anything larger is illegal
- HTRANS_i  in  2  transfer type; NONSEQ/SEQ (bit 1 set) are active
- HWDATA_i  in  32  write data, valid in data phase
- HREADY_i  in  1  bus HREADY (HREADYIN)
- HREADYOUT_o  out  1  slave ready
- HRESP_o  out  1  0 = OKAY, 1 = ERROR
- HRDATA_o  out  32  read data
- mem_en_o  out  1  SRAM access strobe
- mem_we_o  out  4  SRAM byte write enables; all zero means read
- mem_addr_o  out  ADDR_W  SRAM word address
- mem_wdata_o  out  32  SRAM write data
- mem_rdata_i  in  32  SRAM read data, valid the cycle after a read strobe

## Operation
- Accept condition: HSEL_i & HTRANS_i[1] & HREADY_i. On accept, latch offset = HADDR_i−BASE, HWRITE_i and HSIZE_i.
- IDLE/BUSY transfers, unselected transfers, and cycles with HREADY_i low cause no access. The response stays OKAY with zero wait.
- Illegal transfer conditions:
  - HSIZE_i>2
  - HSIZE=2 with addr[1:0]≠0
  - HSIZE=1 with addr[0]=1
  - offset ≥ 4<<ADDR_W
- Illegal transfer response: go to ERR1 then ERR2, with no SRAM access.
- Byte strobes (little-endian):
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'hF
- Reads always return the full word.
- Read: the SRAM read is issued in the accept cycle (mem_addr_o = offset[ADDR_W+1:2]) if the port is free. Data is captured into rdata_q on the next cycle.
- HRDATA_o equals mem_rdata_i in the cycle after a read strobe, and rdata_q otherwise.
- Write: the commit happens in the final data-phase cycle (the one where HREADYOUT_o=1). In that cycle mem_en_o=1, mem_we_o=strobes and mem_wdata_o=HWDATA_i.
- Port conflict: a read accepted in a write-commit cycle is marked pending and issued the following cycle (state RAW). This adds exactly one wait state to the read.
- States:
  - IDLE: no data phase. HREADYOUT_o=1, HRESP_o=0.
  - DATA: wait counter loads WAIT and counts down. HREADYOUT_o=1 only when the counter reaches 0. An accept in the completing cycle re-enters DATA, RAW or ERR1.
  - RAW: issues the pending read. HREADYOUT_o=0. Then goes to DATA with counter=WAIT.
  - ERR1: HREADYOUT_o=0, HRESP_o=1. No accept is possible (HREADY low).
  - ERR2: HREADYOUT_o=1, HRESP_o=1. An accept here is handled normally.

## Timing
- Reset values: HREADYOUT_o=1, HRESP_o=0, HRDATA_o=0, rdata_q=0, mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, state IDLE.
- Reset asserted mid-transfer abandons the transfer and suppresses any pending write commit or RAW read.
- Read latency (accept to HREADYOUT_o=1 with data): 1+WAIT cycles; 2+WAIT after a write commit.
- Write latency: 1+WAIT cycles. The SRAM is updated on the edge ending the completing cycle.
- Back-to-back transfers of the same kind: one per 1+WAIT cycles, no bubbles.
- Read-after-write to the same address returns the new data, because the RAW ordering guarantees it.
- mem_en_o is never asserted for illegal or unaccepted transfers.
- In any single cycle, at most one SRAM access is active.

## Structure
- State enum (IDLE, DATA, RAW, ERR1, ERR2) and the strobe-decode function go in the shared hs32 types package.
- HTRANS/HRESP constants come from the shared AMBA3 include.
- Single module, no sub-modules; the SRAM macro is instantiated outside this block.

## Test plan
- WAIT=0: word write 0xDEADBEEF at 0x10, then back-to-back word read 0x10.
  - The write completes with zero wait and mem_we_o=4'hF.
  - The read's HREADYOUT_o is low for one cycle (RAW), then high with HRDATA_o=0xDEADBEEF.
- Byte write HSIZE=0 at 0x13 with HWDATA=0xAA000000.
  - mem_we_o=4'b1000.
  - A word read at 0x10 returns 0xAAADBEEF.
- Word read at 0x02 (unaligned).
  - ERR1 cycle: HREADYOUT_o=0, HRESP_o=1. ERR2 cycle: HREADYOUT_o=1, HRESP_o=1.
  - mem_en_o stays 0 throughout.
  - A following NONSEQ read at 0x10 in ERR2 completes OKAY.
- WAIT=2 word read at 0x10: HREADYOUT_o is low for 2 cycles, then high with correct data. A consecutive read adds no extra bubble.
- Reset during a WAIT=2 write data phase: on the next cycle HREADYOUT_o=1, HRESP_o=0, mem_en_o=0. The SRAM word is unchanged.
- HTRANS=IDLE with HSEL=1, then HSEL=0 NONSEQ, then NONSEQ with HREADY_i=0: no SRAM access, OKAY with zero wait in every case.

Source files
------------

// File: rtl/hs32_ahb_sram_pkg.sv
// Shared types for the HS32 AHB-lite SRAM bridge: bus constants, FSM states, strobe decode.
package hs32_ahb_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    localparam int unsigned WCNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_RAW,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Attributes of an accepted transfer that live on into its data phase
    typedef struct packed {
        logic       write;
        logic [3:0] strb;
    } xfer_attr_t;

    // Little-endian byte lane strobes for a transfer of the given size
    function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (size)
            3'd0:    strb = 4'(4'b0001 << addr_lo);
            3'd1:    strb = 4'(4'b0011 << addr_lo);
            3'd2:    strb = 4'hF;
            default: strb = 4'h0;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/hs32_ahb_sram.sv
// AHB-lite slave bridging the HS32 data bus onto one single-port synchronous SRAM.
module hs32_ahb_sram
    import hs32_ahb_sram_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter logic [31:0] BASE   = 32'h0,
    parameter int unsigned WAIT   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              HSEL_i,
    input  logic [31:0]       HADDR_i,
    input  logic              HWRITE_i,
    input  logic [2:0]        HSIZE_i,
    input  logic [1:0]        HTRANS_i,
    input  logic [31:0]       HWDATA_i,
    input  logic              HREADY_i,
    output logic              HREADYOUT_o,
    output logic              HRESP_o,
    output logic [31:0]       HRDATA_o,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam int unsigned       OFF_W     = ADDR_W + 2;
    localparam logic [32:0]       WIN_BYTES = 33'(4) << ADDR_W;
    localparam logic [WCNT_W-1:0] WAIT_CNT  = WCNT_W'(WAIT);

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    xfer_attr_t          attr_q, attr_d;
    logic                rd_vld_q, rd_vld_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [31:0]         offset_c;
    logic                illegal_c;
    logic                complete_c;
    logic                commit_c;
    logic                accept_c;
    logic                rd_now_c;
    logic                raw_c;

    // Address-phase decode and data-phase status
    always_comb begin
        offset_c   = HADDR_i - BASE;
        illegal_c  = (HSIZE_i > 3'd2)
                   | ((HSIZE_i == 3'd2) & (HADDR_i[1:0] != 2'b00))
                   | ((HSIZE_i == 3'd1) & HADDR_i[0])
                   | ({1'b0, offset_c} >= WIN_BYTES);
        complete_c = (state_q == ST_IDLE) | (state_q == ST_ERR2)
                   | ((state_q == ST_DATA) & (cnt_q == '0));
        commit_c   = (state_q == ST_DATA) & (cnt_q == '0) & attr_q.write;
        accept_c   = complete_c & HSEL_i & HTRANS_i[1] & HREADY_i;
        rd_now_c   = accept_c & ~illegal_c & ~HWRITE_i & ~commit_c;
        raw_c      = (state_q == ST_RAW);
    end

    // SRAM port: write commit, deferred read, or read issued at accept (mutually exclusive)
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (!reset) begin
            if (commit_c) begin
                mem_en_o    = 1'b1;
                mem_we_o    = attr_q.strb;
                mem_addr_o  = waddr_q;
                mem_wdata_o = HWDATA_i;
            end else if (raw_c) begin
                mem_en_o    = 1'b1;
                mem_addr_o  = waddr_q;
            end else if (rd_now_c) begin
                mem_en_o    = 1'b1;
                mem_addr_o  = offset_c[OFF_W-1:2];
            end
        end
    end

    // Bus response: ready/error from state, read data straight from SRAM right after a strobe
    always_comb begin
        HREADYOUT_o = reset | complete_c;
        HRESP_o     = (~reset & ((state_q == ST_ERR1) | (state_q == ST_ERR2))) ? HRESP_ERROR : HRESP_OKAY;
        HRDATA_o    = reset ? 32'h0 : (rd_vld_q ? mem_rdata_i : rdata_q);
    end

    // Next-state logic: data-phase sequencing, then any new accept overrides
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        waddr_d  = waddr_q;
        attr_d   = attr_q;
        rd_vld_d = raw_c | rd_now_c;
        rdata_d  = rd_vld_q ? mem_rdata_i : rdata_q;

        case (state_q)
            ST_DATA: begin
                if (cnt_q != '0) cnt_d   = cnt_q - WCNT_W'(1);
                else             state_d = ST_IDLE;
            end
            ST_RAW: begin
                state_d = ST_DATA;
                cnt_d   = WAIT_CNT;
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (accept_c) begin
            waddr_d = offset_c[OFF_W-1:2];
            attr_d  = '{write: HWRITE_i, strb: byte_strobe(HSIZE_i, HADDR_i[1:0])};
            if (illegal_c) begin
                state_d = ST_ERR1;
            end else if (!HWRITE_i && commit_c) begin
                state_d = ST_RAW;
            end else begin
                state_d = ST_DATA;
                cnt_d   = WAIT_CNT;
            end
        end
    end

    // State and data registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            waddr_q  <= '0;
            attr_q   <= '0;
            rd_vld_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            waddr_q  <= waddr_d;
            attr_q   <= attr_d;
            rd_vld_q <= rd_vld_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_hs32_ahb_sram.sv
// Bench for hs32_ahb_sram: two instances (WAIT=0 at base 0, WAIT=2 at base 0x400), byte-level memory model.
module tb_hs32_ahb_sram;
    import hs32_ahb_sram_pkg::*;

    localparam int unsigned AW     = 6;
    localparam int unsigned WIN    = 4 << AW;
    localparam logic [31:0] BASE_A = 32'h0000_0000;
    localparam logic [31:0] BASE_B = 32'h0000_0400;
    localparam int unsigned WAIT_A = 0;
    localparam int unsigned WAIT_B = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        hsel, hwrite, hready_ovr, tgt, hready_bus;
    logic [31:0] haddr, hwdata;
    logic [2:0]  hsize;
    logic [1:0]  htrans;

    logic          rdy_a, resp_a, men_a, rdy_b, resp_b, men_b;
    logic [31:0]   rd_a, mwd_a, rd_b, mwd_b;
    logic [31:0]   mrd_a = '0;
    logic [31:0]   mrd_b = '0;
    logic [3:0]    mwe_a, mwe_b;
    logic [AW-1:0] madr_a, madr_b;

    assign hready_bus = hready_ovr ? 1'b0 : (tgt ? rdy_b : rdy_a);

    hs32_ahb_sram #(.ADDR_W(AW), .BASE(BASE_A), .WAIT(WAIT_A)) u_w0 (
        .clk(clk), .reset(rst), .HSEL_i(hsel & ~tgt), .HADDR_i(haddr), .HWRITE_i(hwrite),
        .HSIZE_i(hsize), .HTRANS_i(htrans), .HWDATA_i(hwdata), .HREADY_i(hready_bus),
        .HREADYOUT_o(rdy_a), .HRESP_o(resp_a), .HRDATA_o(rd_a), .mem_en_o(men_a),
        .mem_we_o(mwe_a), .mem_addr_o(madr_a), .mem_wdata_o(mwd_a), .mem_rdata_i(mrd_a));

    hs32_ahb_sram #(.ADDR_W(AW), .BASE(BASE_B), .WAIT(WAIT_B)) u_w2 (
        .clk(clk), .reset(rst), .HSEL_i(hsel & tgt), .HADDR_i(haddr), .HWRITE_i(hwrite),
        .HSIZE_i(hsize), .HTRANS_i(htrans), .HWDATA_i(hwdata), .HREADY_i(hready_bus),
        .HREADYOUT_o(rdy_b), .HRESP_o(resp_b), .HRDATA_o(rd_b), .mem_en_o(men_b),
        .mem_we_o(mwe_b), .mem_addr_o(madr_b), .mem_wdata_o(mwd_b), .mem_rdata_i(mrd_b));

    // Behavioural SRAM macros
    logic [31:0] sram_a [WIN/4];
    logic [31:0] sram_b [WIN/4];
    always @(posedge clk) begin
        if (men_a) begin
            if (mwe_a == 4'h0) mrd_a <= sram_a[madr_a];
            else for (int i = 0; i < 4; i++) if (mwe_a[i]) sram_a[madr_a][8*i +: 8] <= mwd_a[8*i +: 8];
        end
        if (men_b) begin
            if (mwe_b == 4'h0) mrd_b <= sram_b[madr_b];
            else for (int i = 0; i < 4; i++) if (mwe_b[i]) sram_b[madr_b][8*i +: 8] <= mwd_b[8*i +: 8];
        end
    end

    // SRAM access counter per instance
    int acc [2];
    always @(negedge clk) begin
        if (men_a) acc[0] <= acc[0] + 1;
        if (men_b) acc[1] <= acc[1] + 1;
    end

    // Observed signals of the currently targeted instance
    logic        o_rdy, o_resp, o_men;
    logic [31:0] o_rdata, o_mwd, o_madr;
    logic [3:0]  o_mwe;
    always_comb begin
        if (tgt) begin
            o_rdy = rdy_b; o_resp = resp_b; o_men = men_b; o_rdata = rd_b;
            o_mwd = mwd_b; o_madr = 32'(madr_b); o_mwe = mwe_b;
        end else begin
            o_rdy = rdy_a; o_resp = resp_a; o_men = men_a; o_rdata = rd_a;
            o_mwd = mwd_a; o_madr = 32'(madr_a); o_mwe = mwe_a;
        end
    end

    typedef struct {
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gap;
    } xfer_t;

    xfer_t      q[$];
    logic [7:0] exp_mem [2][WIN];
    int         exp_acc [2];
    int         checks   = 0;
    int         failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] base_of(input logic t);
        return t ? BASE_B : BASE_A;
    endfunction

    function automatic int wait_of(input logic t);
        return t ? int'(WAIT_B) : int'(WAIT_A);
    endfunction

    function automatic bit is_legal(input logic t, input logic [31:0] a, input logic [2:0] sz);
        if (sz > 3'd2) return 1'b0;
        if ((a % (32'd1 << sz)) != 0) return 1'b0;
        return (a >= base_of(t)) && ((a - base_of(t)) < WIN);
    endfunction

    function automatic logic [31:0] model_read(input logic t, input logic [31:0] a);
        int unsigned w;
        w = (a - base_of(t)) & ~32'd3;
        return {exp_mem[t][w+3], exp_mem[t][w+2], exp_mem[t][w+1], exp_mem[t][w]};
    endfunction

    function automatic logic [3:0] model_strb(input logic [31:0] a, input logic [2:0] sz);
        logic [3:0] s;
        s = 4'h0;
        for (int i = 0; i < (1 << sz); i++) s[(int'(a[1:0]) + i) % 4] = 1'b1;
        return s;
    endfunction

    task automatic model_write(input logic t, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        int unsigned off;
        off = a - base_of(t);
        for (int i = 0; i < (1 << sz); i++) exp_mem[t][off+i] = d[8*((off+i)%4) +: 8];
    endtask

    task automatic add(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d, input int g);
        xfer_t x;
        x.write = w; x.size = sz; x.addr = a; x.wdata = d; x.gap = g;
        q.push_back(x);
    endtask

    task automatic drive_idle();
        hsel   = 1'($urandom_range(0, 1));
        htrans = HTRANS_IDLE;
        haddr  = $urandom;
        hwrite = 1'($urandom_range(0, 1));
        hsize  = 3'($urandom_range(0, 2));
    endtask

    // Pipelined AHB master: issues queued transfers and checks each data phase at completion
    task automatic run_queue();
        xfer_t dp;
        bit    dp_v, dp_legal, dp_raw, issued, prev_wr;
        int    low, gap, guard;
        dp_v = 0; dp_legal = 0; dp_raw = 0; low = 0; guard = 0;
        gap = (q.size() > 0) ? q[0].gap : 0;
        while ((q.size() > 0 || dp_v) && guard < 20000) begin
            guard++;
            @(posedge clk); #1;
            issued = (q.size() > 0) && (gap == 0);
            if (issued) begin
                hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = q[0].addr;
                hwrite = q[0].write; hsize = q[0].size;
            end else begin
                drive_idle();
            end
            hwdata = (dp_v && dp.write) ? dp.wdata : $urandom;
            @(negedge clk);
            prev_wr = 0;
            if (!dp_v) begin
                chk("idle_ready", 32'(o_rdy), 32'd1);
                chk("idle_resp", 32'(o_resp), 32'd0);
            end else if (o_rdy) begin
                chk("wait_cycles", 32'(low), 32'(dp_legal ? wait_of(tgt) + (dp_raw ? 1 : 0) : 1));
                chk("resp", 32'(o_resp), dp_legal ? 32'd0 : 32'd1);
                if (dp_legal && !dp.write) chk("rdata", o_rdata, model_read(tgt, dp.addr));
                if (dp_legal && dp.write) begin
                    chk("commit_en_we", {27'd0, o_men, o_mwe}, {27'd0, 1'b1, model_strb(dp.addr, dp.size)});
                    chk("commit_addr", o_madr, (dp.addr - base_of(tgt)) >> 2);
                    chk("commit_wdata", o_mwd, dp.wdata);
                    model_write(tgt, dp.addr, dp.size, dp.wdata);
                    prev_wr = 1;
                end
                dp_v = 0;
            end else begin
                low++;
                chk("stall_resp", 32'(o_resp), dp_legal ? 32'd0 : 32'd1);
            end
            if (issued && o_rdy) begin
                dp       = q.pop_front();
                dp_v     = 1;
                low      = 0;
                dp_legal = is_legal(tgt, dp.addr, dp.size);
                dp_raw   = prev_wr && !dp.write;
                if (dp_legal) exp_acc[tgt]++;
                if (q.size() > 0) gap = q[0].gap;
            end else if (!issued && gap > 0) begin
                gap--;
            end
        end
        if (guard >= 20000) begin
            checks++; failures++;
            $error("FAIL queue_timeout observed=%0d cycles expected=completion", guard);
            q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        xfer_t       x;
        int          r, bad;
        int unsigned off;
        hsel = 0; htrans = HTRANS_IDLE; haddr = 0; hwrite = 0; hsize = 0;
        hwdata = 0; hready_ovr = 0; tgt = 0;
        exp_acc[0] = 0; exp_acc[1] = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready_a", 32'(rdy_a), 32'd1);
        chk("rst_resp_a", 32'(resp_a), 32'd0);
        chk("rst_rdata_a", rd_a, 32'd0);
        chk("rst_mem_a", {31'd0, men_a} | 32'(mwe_a) | 32'(madr_a) | mwd_a, 32'd0);
        chk("rst_ready_b", 32'(rdy_b), 32'd1);
        chk("rst_rdata_b", rd_b, 32'd0);

        // Preload both memories through the bus with back-to-back word writes
        for (int t = 0; t < 2; t++) begin
            tgt = 1'(t);
            for (int w = 0; w < int'(WIN / 4); w++) add(1'b1, 3'd2, base_of(tgt) + 32'(4 * w), $urandom, 0);
            run_queue();
        end

        // WAIT=0: write then back-to-back read (RAW), byte write, unaligned word, boundaries
        tgt = 1'b0;
        add(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0);
        add(1'b0, 3'd2, 32'h10, 32'h0, 0);
        run_queue();
        add(1'b1, 3'd0, 32'h13, 32'hAA00_0000, 0);
        add(1'b0, 3'd2, 32'h10, 32'h0, 1);
        run_queue();
        add(1'b0, 3'd2, 32'h02, 32'h0, 0);
        add(1'b0, 3'd2, 32'h10, 32'h0, 0);
        add(1'b0, 3'd2, 32'(WIN - 4), 32'h0, 0);
        add(1'b0, 3'd2, 32'(WIN), 32'h0, 0);
        add(1'b1, 3'd1, 32'h11, 32'h5555_5555, 0);
        add(1'b1, 3'd3, 32'h10, 32'h6666_6666, 0);
        add(1'b1, 3'd1, 32'h12, 32'h1234_5678, 0);
        add(1'b0, 3'd2, 32'h10, 32'h0, 0);
        run_queue();

        // WAIT=2: write, then consecutive reads, and an address just below the window
        tgt = 1'b1;
        add(1'b1, 3'd2, BASE_B + 32'h10, 32'hC0FF_EE01, 0);
        add(1'b0, 3'd2, BASE_B + 32'h10, 32'h0, 0);
        add(1'b0, 3'd2, BASE_B + 32'h10, 32'h0, 0);
        add(1'b0, 3'd1, BASE_B + 32'h16, 32'h0, 0);
        add(1'b0, 3'd2, BASE_B - 32'h4, 32'h0, 0);
        add(1'b0, 3'd0, BASE_B + 32'h11, 32'h0, 0);
        run_queue();

        // Reset in the middle of a WAIT=2 write data phase abandons the write
        @(posedge clk); #1;
        hsel = 1; htrans = HTRANS_NONSEQ; haddr = BASE_B + 32'h20; hwrite = 1; hsize = 3'd2;
        @(negedge clk);
        chk("rstmid_accept_ready", 32'(o_rdy), 32'd1);
        @(posedge clk); #1;
        drive_idle(); hsel = 1'b0; hwdata = 32'h1357_9BDF;
        @(negedge clk);
        chk("rstmid_dphase_stall", 32'(o_rdy), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_ready", 32'(o_rdy), 32'd1);
        chk("rstmid_resp", 32'(o_resp), 32'd0);
        chk("rstmid_mem_en", 32'(o_men), 32'd0);
        add(1'b0, 3'd2, BASE_B + 32'h20, 32'h0, 0);
        run_queue();

        // No access for IDLE, unselected, or HREADY-low address phases
        tgt = 1'b0;
        @(posedge clk); #1;
        hsel = 1; htrans = HTRANS_IDLE; haddr = 32'h10; hwrite = 0; hsize = 3'd2;
        @(negedge clk);
        chk("idle_htrans_ready", 32'(o_rdy), 32'd1);
        chk("idle_htrans_en", 32'(o_men), 32'd0);
        @(posedge clk); #1;
        hsel = 0; htrans = HTRANS_NONSEQ;
        @(negedge clk);
        chk("unsel_ready", 32'(o_rdy), 32'd1);
        chk("unsel_en", 32'(o_men), 32'd0);
        @(posedge clk); #1;
        hsel = 1; hready_ovr = 1;
        @(negedge clk);
        chk("hrdylow_en", 32'(o_men), 32'd0);
        @(posedge clk); #1;
        hready_ovr = 0; hsel = 0; htrans = HTRANS_IDLE;
        @(negedge clk);
        chk("hrdylow_after_ready", 32'(o_rdy), 32'd1);
        chk("hrdylow_after_resp", 32'(o_resp), 32'd0);
        chk("hrdylow_after_en", 32'(o_men), 32'd0);

        // Randomized mixed traffic against the byte model
        for (int t = 0; t < 2; t++) begin
            tgt = 1'(t);
            for (int n = 0; n < 150; n++) begin
                r = int'($urandom_range(0, 99));
                x.write = 1'($urandom_range(0, 1));
                x.size  = (r < 6) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                off     = $urandom_range(0, WIN - 1);
                if (r >= 6 && r < 85) off = off & ~((32'd1 << x.size) - 32'd1);
                x.addr  = base_of(tgt) + off;
                if (r >= 93) begin
                    if (t == 1 && (r % 2) == 0) x.addr = base_of(tgt) - 32'd4 - (off & 32'hFC);
                    else                        x.addr = base_of(tgt) + 32'(WIN) + off;
                end
                x.wdata = $urandom;
                x.gap   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
                q.push_back(x);
            end
            run_queue();
        end

        // Final memory image and access count per instance
        @(negedge clk);
        for (int t = 0; t < 2; t++) begin
            bad = 0;
            for (int w = 0; w < int'(WIN / 4); w++) begin
                if (((t == 0) ? sram_a[w] : sram_b[w]) !==
                    {exp_mem[t][4*w+3], exp_mem[t][4*w+2], exp_mem[t][4*w+1], exp_mem[t][4*w]}) bad++;
            end
            chk((t == 0) ? "sram_image_w0" : "sram_image_w2", 32'(bad), 32'd0);
            chk((t == 0) ? "access_count_w0" : "access_count_w2", 32'(acc[t]), 32'(exp_acc[t]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
